// File: rtl/switch_debounce.sv
// Switch synchroniser and per-channel debouncer with press/release strobes.
// Optional hold-to-repeat Press strobes: define DEBOUNCE_REPEAT_EN.
module switch_debounce #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 17,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] SwitchRaw,
    output logic [WIDTH-1:0] Switch,
    output logic [WIDTH-1:0] Press,
    output logic [WIDTH-1:0] Release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_db
        $error("switch_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
        $error("switch_debounce: repeat timings must be at least 1");
    end

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sw_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rpt;

    // Two-flop synchroniser for the asynchronous pad inputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= SwitchRaw;
            s2 <= s1;
        end
    end

    // Stability counters: accept s2 only after it differs for the full window
    always_comb begin
        sw_d = Switch;
        rise = '0;
        fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == Switch[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i] = '0;
                sw_d[i]  = s2[i];
                rise[i]  = s2[i];
                fall[i]  = ~s2[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Registered level, counters and strobes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            Switch  <= '0;
            Press   <= '0;
            Release <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            Switch  <= sw_d;
            Press   <= rise | rpt;
            Release <= fall;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN

    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                           : REPEAT_PERIOD;
    localparam int RCNT_W = $clog2(RMAX + 1);

    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_WAIT,
        HOLD_REPEAT
    } rpt_state_t;

    rpt_state_t        st_q [WIDTH];
    rpt_state_t        st_d [WIDTH];
    logic [RCNT_W-1:0] rc_q [WIDTH];
    logic [RCNT_W-1:0] rc_d [WIDTH];

    // Repeat state and counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                st_q[i] <= IDLE;
                rc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                st_q[i] <= st_d[i];
                rc_q[i] <= rc_d[i];
            end
        end
    end

    // Hold timing: an accepted fall always wins and suppresses any repeat
    always_comb begin
        rpt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            st_d[i] = st_q[i];
            rc_d[i] = rc_q[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (fall[i]) begin
                st_d[i] = IDLE;
                rc_d[i] = '0;
            end else if (rise[i]) begin
                st_d[i] = HOLD_WAIT;
                rc_d[i] = '0;
            end else begin
                case (st_q[i])
                    IDLE: begin
                        rc_d[i] = '0;
                    end
                    HOLD_WAIT: begin
                        if (rc_q[i] == DELAY_LAST) begin
                            rpt[i]  = 1'b1;
                            st_d[i] = HOLD_REPEAT;
                            rc_d[i] = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + 1'b1;
                        end
                    end
                    HOLD_REPEAT: begin
                        if (rc_q[i] == PERIOD_LAST) begin
                            rpt[i]  = 1'b1;
                            rc_d[i] = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        st_d[i] = IDLE;
                        rc_d[i] = '0;
                    end
                endcase
            end
        end
    end

`else

    // Without repeat support Press follows accepted rises only
    assign rpt = '0;

`endif

endmodule
